// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : byte/half/word load-store initiator for word memory
// Revision 1.0
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        accept;
    logic        misaligned;
    logic        illegal;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready = (state == IDLE) && rst;
    assign accept    = req_valid && req_ready;

    // Full 30-bit word index is compared so high address bits never alias.
    always_comb begin
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        illegal      = req_we ? !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                                  req_funct3 == 3'b010)
                              : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                                 req_funct3 == 3'b111);
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        req_err      = misaligned || illegal || out_of_range;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state == READ) begin
                word_q <= mem_readdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_we && (req_funct3 == 3'b010))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = we_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
        load_half = word_q[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = word_q;
        endcase
    end

    // Sub-word stores splice the new lane into the word captured in READ.
    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        mem_address   = 32'd0;
        mem_write     = 1'b0;
        mem_writedata = 32'd0;
        resp_valid    = 1'b0;
        resp_rdata    = 32'd0;
        resp_err      = 1'b0;
        case (state)
            READ: begin
                mem_address = {addr_q[31:2], 2'b00};
            end
            WRITE: begin
                mem_address   = {addr_q[31:2], 2'b00};
                mem_write     = 1'b1;
                mem_writedata = merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !we_q)
                    resp_rdata = load_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_load_store_unit : table-driven check of load_store_unit against a word memory
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] mem [0:511];
    logic        mem_init;

    int checks;
    int failures;

    load_store_unit #(.MEM_WORDS(512)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_readdata = mem[mem_address[10:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'd0;
            mem[8]   <= 32'h11223344;
            mem[511] <= 32'hCAFEF00D;
        end else if (mem_write) begin
            mem[mem_address[10:2]] <= mem_writedata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          wr_cyc;
        logic        chk;
        int          idx;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int lat, input logic [31:0] rdata, input logic err,
                                input int wr_cyc, input logic chk, input int idx,
                                input logic [31:0] word);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.rdata = rdata; v.err = err; v.wr_cyc = wr_cyc;
        v.chk = chk; v.idx = idx; v.word = word;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        int writes;
        int first_wr;
        logic [31:0] rd;
        logic er;
        lat = 0; writes = 0; first_wr = 0; rd = 32'hX; er = 1'bX;
        req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        check({v.name, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (mem_write) begin
                writes++;
                if (first_wr == 0) first_wr = c;
            end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " rdata"}, rd, v.rdata);
        check({v.name, " err"}, {31'd0, er}, {31'd0, v.err});
        check({v.name, " write_count"}, writes, (v.wr_cyc > 0) ? 1 : 0);
        check({v.name, " write_cycle"}, first_wr, v.wr_cyc);
        @(posedge clk); #1;
        check({v.name, " resp_drop"}, {31'd0, resp_valid}, 32'd0);
        if (v.chk) check({v.name, " mem"}, mem[v.idx], v.word);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;

        vecs.push_back(mk("SW 10",     1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 0, 1, 1, 4, 32'hDEADBEEF));
        vecs.push_back(mk("LB 13",     0, 3'b000, 32'h13, 0, 2, 32'hFFFFFFDE, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LBU 13",    0, 3'b100, 32'h13, 0, 2, 32'h000000DE, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LH 12",     0, 3'b001, 32'h12, 0, 2, 32'hFFFFDEAD, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LHU 10",    0, 3'b101, 32'h10, 0, 2, 32'h0000BEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LW 10",     0, 3'b010, 32'h10, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("SB 11",     1, 3'b000, 32'h11, 32'h000000AA, 3, 0, 0, 2, 1, 4, 32'hDEADAAEF));
        vecs.push_back(mk("SH 12",     1, 3'b001, 32'h12, 32'h00001234, 3, 0, 0, 2, 1, 4, 32'h1234AAEF));
        vecs.push_back(mk("LB 10",     0, 3'b000, 32'h10, 0, 2, 32'hFFFFFFEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LBU 11",    0, 3'b100, 32'h11, 0, 2, 32'h000000AA, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LH 10",     0, 3'b001, 32'h10, 0, 2, 32'hFFFFAAEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LHU 12",    0, 3'b101, 32'h12, 0, 2, 32'h00001234, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LW 7FC",    0, 3'b010, 32'h7FC, 0, 2, 32'hCAFEF00D, 0, 0, 0, 0, 0));
        vecs.push_back(mk("LW 06 err", 0, 3'b010, 32'h06, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("LH 05 err", 0, 3'b001, 32'h05, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("L f3=011",  0, 3'b011, 32'h10, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("SW 800",    1, 3'b010, 32'h800, 32'h12345678, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("LW hi wrap", 0, 3'b010, 32'h80000010, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("S f3=100",  1, 3'b100, 32'h10, 32'h00000077, 1, 0, 1, 0, 1, 4, 32'h1234AAEF));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst req_ready", {31'd0, req_ready}, 32'd0);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst mem_write", {31'd0, mem_write}, 32'd0);
        check("rst mem_address", mem_address, 32'd0);
        check("rst mem_writedata", mem_writedata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back with req_valid held; inputs change mid-operation
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_funct3 = 3'b100; req_addr = 32'h13; req_wdata = 32'hFFFFFFFF;
        check("b2b c1 ready", {31'd0, req_ready}, 32'd0);
        check("b2b c1 resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("b2b c2 ready", {31'd0, req_ready}, 32'd0);
        check("b2b c2 resp", {31'd0, resp_valid}, 32'd1);
        check("b2b first rdata", resp_rdata, 32'h1234AAEF);
        @(posedge clk); #1;
        check("b2b c3 ready", {31'd0, req_ready}, 32'd1);
        check("b2b c3 resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b c4 ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("b2b second resp", {31'd0, resp_valid}, 32'd1);
        check("b2b second rdata", resp_rdata, 32'h00000012);
        @(posedge clk); #1;

        // Reset during the WRITE cycle of SB 0x20
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort read addr", mem_address, 32'h20);
        check("abort read no write", {31'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        check("abort write cycle", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort mem_write drop", {31'd0, mem_write}, 32'd0);
        check("abort ready low", {31'd0, req_ready}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("abort no resp", {31'd0, resp_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort ready back", {31'd0, req_ready}, 32'd1);
        check("abort no resp after", {31'd0, resp_valid}, 32'd0);
        check("abort mem word 8", mem[8], 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side load/store unit between the core datapath and the word-organised DataMemory.
- Accepts one byte, halfword or word load/store request at a time from the core.
- Converts each request into word-aligned memory accesses; sub-word stores use read-modify-write.
- Returns extended load data, or an error, with a one-cycle response pulse.

Parameters:
- MEM_WORDS, 512: number of 32-bit words in the attached memory. Word index addr[31:2] >= MEM_WORDS is an error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/halfword used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3 or out-of-range; valid with resp_valid
- mem_address  out  32  word-aligned byte address to memory
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  full word to memory
- mem_readdata  in  32  combinational read data for mem_address

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- While rst=0:
  - state=IDLE, all request latches cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_write=0, mem_address=0, mem_writedata=0.
  - req_ready=0.
- Handshake:
  - req_ready = (state==IDLE) && rst.
  - A request is accepted on the rising edge where req_valid && req_ready.
  - At acceptance, latch req_we, req_funct3, req_addr and req_wdata. Later input changes are ignored until the next IDLE.
- Error check, made at acceptance:
  - H/HU with addr[0]!=0 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - Loads: funct3 011, 110, 111 are illegal.
  - Stores: any funct3 other than 000/001/010 is illegal.
  - addr[31:2] >= MEM_WORDS is out of range.
  - On any error: go to RESP, resp_err=1, no memory access of any kind.
- States: IDLE, READ, WRITE, RESP.
- Transitions:
  - Load: IDLE -> READ -> RESP -> IDLE.
  - SW: IDLE -> WRITE -> RESP -> IDLE.
  - SB/SH: IDLE -> READ -> WRITE -> RESP -> IDLE.
- READ state:
  - mem_address = {addr[31:2],2'b00}, mem_write=0.
  - Capture mem_readdata into the internal word register on the edge leaving READ.
- WRITE state:
  - mem_address as in READ, mem_write=1.
  - SW: mem_writedata = wdata.
  - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: captured word with halfword lane addr[1] replaced by wdata[15:0].
  - Little-endian lanes: byte 0 = bits[7:0].
- mem_address=0, mem_write=0 and mem_writedata=0 in IDLE and RESP.
- RESP state:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata, loads: lane selected by addr[1:0].
    - B/H sign-extended from bit 7/15.
    - BU/HU zero-extended.
    - W passed unmodified.
  - resp_rdata = 0 for stores and errors.
  - resp_rdata and resp_err are 0 whenever resp_valid=0.
- Latency, acceptance edge to resp_valid:
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Back-to-back: req_ready rises in the cycle after RESP. No request is accepted during RESP.
- Reset mid-operation:
  - Asserting rst in any state forces IDLE and drops mem_write immediately.
  - An aborted SB/SH leaves memory unwritten. No resp_valid is produced for the aborted request.
- Address wrap: none. The word index is checked against MEM_WORDS only. The top two address bits are never dropped silently.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF:
  - Required: resp_valid 2 cycles after acceptance, resp_err=0, resp_rdata=0.
  - Memory word 4 = 0xDEADBEEF.
  - mem_write high for exactly 1 cycle.
- After SW addr 0x10 data 0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
  - LW 0x10 -> 0xDEADBEEF.
- After SW addr 0x10 data 0xDEADBEEF, SB 0x11 data 0x000000AA:
  - Required: memory word 4 = 0xDEADAABE... corrected: 0xDEADAAEF.
  - Latency 3 cycles, READ precedes WRITE.
  - Then SH 0x12 data 0x1234 -> word 4 = 0x1234AAEF.
- Errors:
  - LW 0x06 -> resp_err=1 after 1 cycle, mem_write never high, resp_rdata=0.
  - LH 0x05 -> resp_err=1.
  - Load funct3 011 -> resp_err=1.
  - SW 0x800 (word 512) -> resp_err=1.
- Back-to-back requests with req_valid held high:
  - req_ready=0 from acceptance through RESP.
  - Second request accepted the cycle after RESP.
  - Inputs changed mid-operation do not affect the first result.
- Reset mid-operation: assert rst low during the WRITE cycle of SB 0x20 data 0x55.
  - Required: mem_write falls immediately, memory word 8 unchanged, no resp_valid.
  - req_ready returns to 1 one cycle after rst releases.
